addr4u_seq_ctrl: RTL and testbench
==================================

// Module: addr4u_seq_ctrl
// PURPOSE
//  Sequences one shared 4-bit unsigned adder slice (A+B -> 5-bit O, no carry-in) to compute WIDTH-bit sums.
//  The block processes one 4-bit slice per pass, LSB first. A carry-in is injected by a second increment pass.
//  Sits between a valid/ready requester and one fault-resilient addr4u instance.
//  When the adder is idle, the block drives its operands to zero to minimise switching power.
// PARAMETERS
//  WIDTH      16  operand width; multiple of 4, >=4; NSL = WIDTH/4 slices
//  MAX_RETRY  3   recheck retries per pass (used only with ADDR_RECHECK_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand request
//  in_ready   out  1        1 only in IDLE
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        result consumed
//  out_sum    out  WIDTH+1  in_a+in_b (MSB = carry out)
//  out_err    out  1        recheck exhausted on some pass (constant 0 without ADDR_RECHECK_EN)
//  add_a      out  4        adder operand A
//  add_b      out  4        adder operand B
//  add_s      in   5        adder result; combinational, sampled in the same cycle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; out_valid=0; out_sum=0; out_err=0; add_a=add_b=0; carry/slice/retry=0.
//   in_ready is decoded from state, so it is 1 after reset.
//  States: IDLE, ADD, INC, (CHK with recheck enabled), DONE.
//  IDLE: on in_valid&in_ready at an edge, latch in_a/in_b, clear carry, slice=0 -> ADD. add_a=add_b=0.
//  ADD:  add_a=A[4i+3:4i], add_b=B[4i+3:4i]; capture tmp=add_s.
//   If carry==0: sum slice=tmp[3:0]; carry=tmp[4]; next slice.
//   If carry==1: -> INC.
//  INC:  add_a=tmp[3:0], add_b=4'b0001; sum slice=add_s[3:0]; carry=tmp[4]|add_s[4]; next slice.
//  Next slice: if i==NSL-1, out_sum[WIDTH]=carry and -> DONE; else i+1 -> ADD.
//  Latency: one cycle per pass, NSL to 2*NSL pass cycles. out_valid rises the cycle after the last pass.
//  DONE: out_valid=1; out_sum/out_err stable; in_valid ignored.
//   On out_ready: out_valid=0 at that edge -> IDLE. No accept in the same cycle.
//  out_sum is written only on entry to DONE; it is not cleared on handshake and keeps its last value.
//  Reset mid-operation: the transaction is discarded and no out_valid is produced.
//  Operand changes after acceptance have no effect.
// CONFIGURATION
//  Macro ADDR_RECHECK_EN (temporal redundancy against transient adder faults):
//   Defined:
//    - Each ADD/INC pass is followed by a CHK cycle that recomputes the pass with add_a/add_b swapped.
//    - Match: commit the pass result.
//    - Mismatch: repeat the pass and its CHK, retry++.
//    - retry==MAX_RETRY with mismatch: commit the CHK result, set sticky err, continue.
//    - retry clears per pass; err clears on accept.
//    - out_err = err in DONE.
//    - Pass latency is 2 cycles minimum.
//   Undefined: no CHK state, no retry counter; out_err tied 0.
// TESTING
//  1 in_a=16'h1234,in_b=16'h4321 -> out_sum=17'h05555; 4 pass cycles; out_valid in 5th cycle after accept.
//  2 in_a=16'hFFFF,in_b=16'h0001 -> out_sum=17'h10000; 7 pass cycles (slices 1-3 use INC).
//  3 in_a=in_b=16'hFFFF -> 17'h1FFFE; then hold out_ready=0 for 5 cycles -> out_sum/out_valid stable,
//    in_ready=0, concurrent in_valid ignored.
//  4 rst_n low mid-slice 2 -> out_valid=0, add_a=add_b=0 immediately; in_ready=1;
//    next request 16'h0F0F+16'h00F1 -> 17'h01000.
//  5 ADDR_RECHECK_EN, adder model corrupts one ADD pass once -> out_sum correct, out_err=0, one extra pass.
//  6 ADDR_RECHECK_EN, adder bit 0 stuck-at-1 -> out_err=1 after MAX_RETRY retries; cleared on next accept.

Source files
------------

// File: rtl/addr4u_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : addr4u_seq_ctrl
// Brief    : Builds a WIDTH-bit adder from one shared 4-bit adder slice, one
//            slice per pass, LSB first. Macro ADDR_RECHECK_EN adds a swapped-
//            operand recheck pass with bounded retries and a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module addr4u_seq_ctrl #(
  parameter int WIDTH     = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_err,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  input  logic [4:0]       add_s
);

  localparam int c_NSL = WIDTH / 4;
  localparam int c_SW  = (c_NSL > 1) ? $clog2(c_NSL) : 1;

  if (WIDTH < 4 || (WIDTH % 4) != 0 || MAX_RETRY < 0) begin : g_param_check
    $error("addr4u_seq_ctrl: WIDTH must be a multiple of 4 (>=4), MAX_RETRY >= 0");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_INC  = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;         // remaining operand slices, next one in [3:0]
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_inc_carry;
  logic [c_SW-1:0]  r_slice;

  logic             w_commit;
  logic             w_inc;
  logic             w_to_inc;
  logic             w_last;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_acc_nxt;

`ifdef ADDR_RECHECK_EN
  localparam int c_RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [4:0]       r_pass;
  logic             r_is_inc;
  logic [c_RW-1:0]  r_retry;
  logic             r_err;
  logic             w_mismatch;

  assign w_mismatch = (r_state == S_CHK) && (add_s != r_pass);
  // Commit on agreement, or give up and take the recheck result once retries run out.
  assign w_commit   = (r_state == S_CHK) &&
                      (!w_mismatch || (r_retry == c_RW'(MAX_RETRY)));
  assign w_inc      = r_is_inc;
`else
  assign w_commit   = (r_state == S_ADD) || (r_state == S_INC);
  assign w_inc      = (r_state == S_INC);
  assign out_err    = 1'b0;
`endif

  assign in_ready    = (r_state == S_IDLE);
  assign w_to_inc    = !w_inc && r_carry;
  assign w_last      = (r_slice == c_SW'(c_NSL - 1));
  assign w_carry_nxt = w_inc ? (r_inc_carry | add_s[4]) : add_s[4];

  if (WIDTH == 4) begin : g_acc_single
    assign w_acc_nxt = add_s[3:0];
  end else begin : g_acc_multi
    assign w_acc_nxt = {add_s[3:0], r_acc[WIDTH-1:4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_inc_carry <= 1'b0;
      r_slice     <= '0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      add_a       <= 4'd0;
      add_b       <= 4'd0;
`ifdef ADDR_RECHECK_EN
      r_pass      <= 5'd0;
      r_is_inc    <= 1'b0;
      r_retry     <= '0;
      r_err       <= 1'b0;
      out_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            add_a   <= in_a[3:0];
            add_b   <= in_b[3:0];
            r_a     <= in_a >> 4;
            r_b     <= in_b >> 4;
            r_carry <= 1'b0;
            r_slice <= '0;
            r_state <= S_ADD;
`ifdef ADDR_RECHECK_EN
            r_retry <= '0;
            r_err   <= 1'b0;
            out_err <= 1'b0;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
`ifdef ADDR_RECHECK_EN
        S_ADD, S_INC: begin
          r_pass   <= add_s;
          r_is_inc <= (r_state == S_INC);
          add_a    <= add_b;
          add_b    <= add_a;
          r_state  <= S_CHK;
        end
        S_CHK: begin
          if (!w_commit) begin
            r_retry <= r_retry + 1'b1;
            add_a   <= add_b;
            add_b   <= add_a;
            r_state <= r_is_inc ? S_INC : S_ADD;
          end
        end
`endif
        default: begin
        end
      endcase

      if (w_commit) begin
`ifdef ADDR_RECHECK_EN
        r_retry <= '0;
        if (w_mismatch) r_err <= 1'b1;
`endif
        if (w_to_inc) begin
          // Incoming carry is folded in by a second pass: slice result + 1.
          r_inc_carry <= add_s[4];
          add_a       <= add_s[3:0];
          add_b       <= 4'b0001;
          r_state     <= S_INC;
        end else begin
          r_acc   <= w_acc_nxt;
          r_carry <= w_carry_nxt;
          if (w_last) begin
            out_sum   <= {w_carry_nxt, w_acc_nxt};
            out_valid <= 1'b1;
            add_a     <= 4'd0;
            add_b     <= 4'd0;
            r_state   <= S_DONE;
`ifdef ADDR_RECHECK_EN
            out_err   <= r_err | w_mismatch;
`endif
          end else begin
            r_slice <= r_slice + 1'b1;
            add_a   <= r_a[3:0];
            add_b   <= r_b[3:0];
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_state <= S_ADD;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr4u_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr4u_seq_ctrl
// Brief    : Scoreboard bench for addr4u_seq_ctrl with a behavioural 4-bit
//            adder model (fault hooks used when ADDR_RECHECK_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_addr4u_seq_ctrl;

  localparam int WIDTH     = 16;
  localparam int NSL       = WIDTH / 4;
  localparam int MAX_RETRY = 3;
`ifdef ADDR_RECHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_err;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic [4:0]       add_s;

  logic             fault_once;
  logic             stuck_a0;
  logic             hold_ready;
  int               cyc;
  int               n_checks;
  int               n_pass;
  bit               seen;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           err;
    int             lat;
    bit             chk_sum;
    bit             chk_lat;
    int             acc_cyc;
  } exp_t;

  exp_t q[$];

  addr4u_seq_ctrl #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err), .add_a(add_a), .add_b(add_b),
    .add_s(add_s)
  );

  // Adder slice model: A input bit 0 may be stuck high, result bit 0 may flip once.
  always_comb begin
    add_s = ({1'b0, add_a | {3'b000, stuck_a0}} + {1'b0, add_b}) ^ {4'b0000, fault_once};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pass count: one per slice plus one increment pass for every slice above 0 with a carry in.
  function automatic int ref_passes(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = NSL;
    for (int i = 1; i < NSL; i++) begin
      longint unsigned m  = (64'd1 << (4 * i)) - 1;
      longint unsigned lo = (longint'(a) & m) + (longint'(b) & m);
      if ((lo >> (4 * i)) != 0) n++;
    end
    return n;
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on the first cycle each result is presented.
  exp_t cur;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got sum %0h with no request pending", out_sum);
        end else begin
          cur = q.pop_front();
          if (cur.chk_sum) check("sum", 32'(out_sum), 32'(cur.sum));
          if (cur.chk_lat) check("latency", 32'(cyc - cur.acc_cyc), 32'(cur.lat));
          check("err", 32'(out_err), 32'(cur.err));
        end
      end else if (cur.chk_sum) begin
        check("sum_hold", 32'(out_sum), 32'(cur.sum));
      end
      check("in_ready_busy", 32'(in_ready), 32'd0);
      check("adder_idle", {24'd0, add_a, add_b}, 32'd0);
      if (out_ready) seen = 1'b0;
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input bit inject, input bit stuck_case);
    exp_t e;
    int   t = 0;
    while (!in_ready) begin
      if (t == 300) begin
        n_checks++;
        $display("FAIL send_timeout: in_ready still %0b after %0d cycles", in_ready, t);
        return;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    e.sum     = {1'b0, a} + {1'b0, b};
    e.err     = stuck_case;
    e.lat     = (RC ? 2 : 1) * ref_passes(a, b) + (inject ? 2 : 0);
    e.chk_sum = !stuck_case;
    e.chk_lat = !stuck_case;
    e.acc_cyc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    if (inject) begin
      fault_once = 1'b1;
      @(posedge clk);
      #1;
      fault_once = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 || !in_ready || out_valid) begin
      if (t == 500) begin
        n_checks++;
        $display("FAIL drain_timeout: %0d results still pending", q.size());
        q.delete();
        return;
      end
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    seen       = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    fault_once = 1'b0;
    stuck_a0   = 1'b0;
    hold_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_adder_ops", {24'd0, add_a, add_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_drain();

    // Result held while the consumer stalls; a new request must be ignored.
    hold_ready = 1'b1;
    send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    for (int t = 0; t < 300 && !out_valid; t++) @(negedge clk);
    check("stall_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_a     = 16'h0101;
    in_b     = 16'h0202;
    repeat (5) @(negedge clk);
    check("stall_sum", 32'(out_sum), 32'h1FFFE);
    in_valid   = 1'b0;
    hold_ready = 1'b0;
    wait_drain();

    // Asynchronous reset during slice 2 discards the transaction.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    repeat (RC ? 4 : 2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_adder_ops", {24'd0, add_a, add_b}, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_drain();

`ifdef ADDR_RECHECK_EN
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_drain();
    stuck_a0 = 1'b1;
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    wait_drain();
    stuck_a0 = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_drain();
`endif

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) b = ~a + WIDTH'($urandom_range(0, 2));
      else b = WIDTH'($urandom);
      send(a, b, 1'b0, 1'b0);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
